// File: rtl/lfsr_checker.sv
// Checks a received Fibonacci XNOR LFSR stream: hunts for LOCK_COUNT consecutive predicted
// words, then flywheels its own predictor and counts mismatches until UNLOCK_ERRS misses in a row.
module lfsr_checker #(
    parameter int NUM_BITS    = 4,
    parameter int LOCK_COUNT  = 4,
    parameter int UNLOCK_ERRS = 2
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic                i_Data_DV,
    input  logic [NUM_BITS-1:0] i_Data,
    input  logic                i_Clear_Err,
    output logic                o_Locked,
    output logic                o_Err,
    output logic [15:0]         o_Err_Count
);

    typedef enum logic {HUNT, LOCKED} state_t;

    // Feedback tap positions for each supported width, bit 0 = tap 1.
    function automatic logic [7:0] tap_mask(input int n);
        case (n)
            3:       return 8'b0000_0110;
            4:       return 8'b0000_1100;
            5:       return 8'b0001_0100;
            6:       return 8'b0011_0000;
            7:       return 8'b0110_0000;
            default: return 8'b1011_1000;
        endcase
    endfunction

    localparam logic [7:0]          TAP_MASK_FULL = tap_mask(NUM_BITS);
    localparam logic [NUM_BITS-1:0] TAPS          = TAP_MASK_FULL[NUM_BITS-1:0];
    localparam logic [NUM_BITS-1:0] ALL_ONES      = '1;
    localparam logic [3:0]          LOCK_CNT      = 4'(LOCK_COUNT);
    localparam logic [3:0]          UNLOCK_CNT    = 4'(UNLOCK_ERRS);

    function automatic logic [NUM_BITS-1:0] lfsr_next(input logic [NUM_BITS-1:0] x);
        return {x[NUM_BITS-2:0], ~^(x & TAPS)};
    endfunction

    state_t              state_reg, state_next;
    logic [NUM_BITS-1:0] prev_reg, prev_next;
    logic [NUM_BITS-1:0] expected_reg, expected_next;
    logic [3:0]          match_reg, match_next;
    logic [3:0]          miss_reg, miss_next;
    logic                first_reg, first_next;
    logic                err_reg, err_next;
    logic [15:0]         err_count_reg, err_count_next;
    logic                err_counted;

    always_comb begin
        state_next     = state_reg;
        prev_next      = prev_reg;
        expected_next  = expected_reg;
        match_next     = match_reg;
        miss_next      = miss_reg;
        first_next     = first_reg;
        err_next       = 1'b0;
        err_count_next = err_count_reg;
        err_counted    = 1'b0;

        if (i_Data_DV) begin
            case (state_reg)
                HUNT: begin
                    prev_next = i_Data;
                    if (first_reg) begin
                        first_next = 1'b0;
                    end else if (i_Data != ALL_ONES && i_Data == lfsr_next(prev_reg)) begin
                        if (4'(match_reg + 4'd1) == LOCK_CNT) begin
                            state_next    = LOCKED;
                            expected_next = lfsr_next(i_Data);
                            match_next    = 4'd0;
                        end else begin
                            match_next = 4'(match_reg + 4'd1);
                        end
                    end else begin
                        match_next = 4'd0;
                    end
                end
                LOCKED: begin
                    // Predictor free-runs; received data never reseeds it.
                    expected_next = lfsr_next(expected_reg);
                    if (i_Data != expected_reg) begin
                        err_next    = 1'b1;
                        err_counted = 1'b1;
                        if (4'(miss_reg + 4'd1) == UNLOCK_CNT) begin
                            state_next = HUNT;
                            miss_next  = 4'd0;
                            first_next = 1'b1;
                        end else begin
                            miss_next = 4'(miss_reg + 4'd1);
                        end
                    end else begin
                        miss_next = 4'd0;
                    end
                end
                default: state_next = HUNT;
            endcase
        end

        if (err_counted && err_count_reg != 16'hFFFF)
            err_count_next = err_count_reg + 16'd1;
        if (i_Clear_Err)
            err_count_next = err_counted ? 16'd1 : 16'd0;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_reg     <= HUNT;
            prev_reg      <= '0;
            expected_reg  <= '0;
            match_reg     <= 4'd0;
            miss_reg      <= 4'd0;
            first_reg     <= 1'b1;
            err_reg       <= 1'b0;
            err_count_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            prev_reg      <= prev_next;
            expected_reg  <= expected_next;
            match_reg     <= match_next;
            miss_reg      <= miss_next;
            first_reg     <= first_next;
            err_reg       <= err_next;
            err_count_reg <= err_count_next;
        end
    end

    assign o_Locked    = (state_reg == LOCKED);
    assign o_Err       = err_reg;
    assign o_Err_Count = err_count_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker (4-bit LFSR: 0,1,3,7,E,D,B,6,C,9,2,5,A,4,8,0).
module tb_lfsr_checker;

    logic        clk;
    logic        rst_n;
    logic        data_dv;
    logic [3:0]  data;
    logic        clear_err;
    logic        locked;
    logic        err;
    logic [15:0] err_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    lfsr_checker #(.NUM_BITS(4), .LOCK_COUNT(4), .UNLOCK_ERRS(2)) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Data_DV   (data_dv),
        .i_Data      (data),
        .i_Clear_Err (clear_err),
        .o_Locked    (locked),
        .o_Err       (err),
        .o_Err_Count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One valid word; returns 1ns after the capturing edge so outputs are settled.
    task automatic send_word(input logic [3:0] d, input logic clr);
        @(negedge clk);
        data_dv   = 1'b1;
        data      = d;
        clear_err = clr;
        @(posedge clk);
        #1;
        data_dv   = 1'b0;
        clear_err = 1'b0;
        $display("word %h clr=%0b -> locked=%0b err=%0b count=%0d", d, clr, locked, err, err_count);
    endtask

    task automatic idle(input int n, input logic clr);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_dv   = 1'b0;
            clear_err = clr;
            @(posedge clk);
            #1;
            clear_err = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total_cnt++;
        if (act !== req) $display("FAIL %s: got %0h, expected %0h", name, act, req);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; data_dv = 1'b0; data = 4'h0; clear_err = 1'b0;
        #12;
        if (locked !== 1'b0) $display("FAIL reset_locked: got %0b, expected 0", locked); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3, 1'b0);
        check("post_reset_locked", {15'd0, locked}, 16'd0);
        check("post_reset_err", {15'd0, err}, 16'd0);
        check("post_reset_count", err_count, 16'd0);
    endtask

    task automatic test_lock;
        logic [3:0] seq [5] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE};
        for (int i = 0; i < 5; i++) begin
            send_word(seq[i], 1'b0);
            check("lock_no_err", {15'd0, err}, 16'd0);
            check("lock_state", {15'd0, locked}, (i == 4) ? 16'd1 : 16'd0);
        end
    endtask

    task automatic test_single_err;
        send_word(4'hF, 1'b0);
        check("single_err_pulse", {15'd0, err}, 16'd1);
        check("single_err_count", err_count, 16'd1);
        check("single_err_locked", {15'd0, locked}, 16'd1);
        send_word(4'hB, 1'b0);
        check("single_after_err", {15'd0, err}, 16'd0);
        check("single_after_locked", {15'd0, locked}, 16'd1);
        send_word(4'h6, 1'b0);
        send_word(4'hC, 1'b0);
        check("single_resync_err", {15'd0, err}, 16'd0);
        idle(2, 1'b0);
        check("idle_count_hold", err_count, 16'd1);
        check("idle_locked_hold", {15'd0, locked}, 16'd1);
    endtask

    task automatic test_unlock;
        send_word(4'h0, 1'b0);
        check("unlock_err1", {15'd0, err}, 16'd1);
        check("unlock_count1", err_count, 16'd2);
        check("unlock_locked1", {15'd0, locked}, 16'd1);
        send_word(4'h0, 1'b0);
        check("unlock_err2", {15'd0, err}, 16'd1);
        check("unlock_count2", err_count, 16'd3);
        check("unlock_locked2", {15'd0, locked}, 16'd0);
    endtask

    task automatic test_hunt_lockup;
        for (int i = 0; i < 20; i++) begin
            send_word(4'hF, 1'b0);
            check("lockup_locked", {15'd0, locked}, 16'd0);
            check("lockup_err", {15'd0, err}, 16'd0);
        end
        check("lockup_count", err_count, 16'd3);
    endtask

    task automatic test_gaps_and_clear;
        logic [3:0] lock_seq [5] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE};
        logic [3:0] gap_seq  [4] = '{4'hD, 4'hB, 4'h6, 4'hC};
        foreach (lock_seq[i]) send_word(lock_seq[i], 1'b0);
        check("relock", {15'd0, locked}, 16'd1);
        foreach (gap_seq[i]) begin
            send_word(gap_seq[i], 1'b0);
            check("gap_err", {15'd0, err}, 16'd0);
            idle(3, 1'b0);
            check("gap_locked", {15'd0, locked}, 16'd1);
        end
        check("gap_count", err_count, 16'd3);
        send_word(4'h0, 1'b1);
        check("clear_with_err_count", err_count, 16'd1);
        check("clear_with_err_pulse", {15'd0, err}, 16'd1);
        idle(1, 1'b1);
        check("clear_only_count", err_count, 16'd0);
        check("clear_err_low", {15'd0, err}, 16'd0);
        send_word(4'h2, 1'b0);
        check("after_clear_match", {15'd0, err}, 16'd0);
        check("after_clear_locked", {15'd0, locked}, 16'd1);
    endtask

    task automatic test_reset_mid;
        logic [3:0] seq [5] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD};
        send_word(4'h0, 1'b0);
        check("mid_pre_count", err_count, 16'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_locked", {15'd0, locked}, 16'd0);
        check("mid_rst_count", err_count, 16'd0);
        check("mid_rst_err", {15'd0, err}, 16'd0);
        idle(1, 1'b0);
        rst_n = 1'b1;
        idle(1, 1'b0);
        foreach (seq[i]) begin
            send_word(seq[i], 1'b0);
            check("mid_relock", {15'd0, locked}, (i == 4) ? 16'd1 : 16'd0);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_err();
        test_unlock();
        test_hunt_lockup();
        test_gaps_and_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
